// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed multi-channel FIR.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  // Widest accumulator / sample that round_sat can handle.
  localparam int MAX_ACC_W  = 128;
  localparam int MAX_DATA_W = 64;

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int tap_aw(input int n_taps);
    return (n_taps > 1) ? $clog2(n_taps) : 1;
  endfunction

  // Round half up after an arithmetic right shift, then clamp to a data_w-bit signed range.
  function automatic logic signed [MAX_DATA_W-1:0] round_sat(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          out_shift,
    input int                          data_w
  );
    logic signed [MAX_ACC_W-1:0] one;
    logic signed [MAX_ACC_W-1:0] r;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    one = MAX_ACC_W'(1);
    r   = acc;
    if (out_shift > 0) r = (acc + (one <<< (out_shift - 1))) >>> out_shift;
    hi = (one <<< (data_w - 1)) - one;
    lo = -(one <<< (data_w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return MAX_DATA_W'(r);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register banks with a deferred, sample-aligned bank swap.
module fir_coef_bank #(
  parameter int                         N_TAPS  = 33,
  parameter int                         COEFF_W = 32,
  parameter int                         TAP_AW  = 6,
  parameter logic [N_TAPS*COEFF_W-1:0]  COEFFS  = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      coef_we,
  input  logic [TAP_AW-1:0]         coef_addr,
  input  logic signed [COEFF_W-1:0] coef_wdata,
  input  logic                      coef_swap,
  input  logic                      swap_allow,
  input  logic [TAP_AW-1:0]         rd_idx,
  output logic signed [COEFF_W-1:0] rd_data,
  output logic                      swap_pending
);

  logic signed [COEFF_W-1:0] shadow_q [N_TAPS];
  logic signed [COEFF_W-1:0] shadow_d [N_TAPS];
  logic signed [COEFF_W-1:0] active_q [N_TAPS];
  logic signed [COEFF_W-1:0] active_d [N_TAPS];
  logic                      pending_q;
  logic                      pending_d;
  logic                      do_swap;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    do_swap   = pending_q && swap_allow;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q | coef_swap;
    // The copy reads shadow_q, so a write on the swap edge lands only in the new shadow.
    if (do_swap) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (coef_we && (int'(coef_addr) < N_TAPS)) shadow_d[coef_addr] = coef_wdata;
  end

  // NOTE: the banks are flops rather than RAM, so loading COEFFS on reset is a plain register reset.
  // NOTE: sequential state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        shadow_q[k] <= COEFFS[k*COEFF_W +: COEFF_W];
        active_q[k] <= COEFFS[k*COEFF_W +: COEFF_W];
      end
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign rd_data      = (int'(rd_idx) < N_TAPS) ? active_q[rd_idx] : '0;
  assign swap_pending = pending_q;

endmodule

// File: rtl/fir_tdm_mc.sv
// Multi-channel FIR sharing one registered multiplier and accumulator across all taps and channels.
module fir_tdm_mc
  import fir_pkg::*;
#(
  parameter int                        N_TAPS    = 33,
  parameter int                        DATA_W    = 24,
  parameter int                        COEFF_W   = 32,
  parameter int                        N_CH      = 4,
  parameter int                        ACC_W     = 64,
  parameter int                        OUT_SHIFT = 30,
  parameter logic [N_TAPS*COEFF_W-1:0] COEFFS    =
    {{((N_TAPS - 1) * COEFF_W){1'b0}}, COEFF_W'(64'd1 << OUT_SHIFT)},
  localparam int                       CH_W      = ch_w(N_CH),
  localparam int                       TAP_AW    = tap_aw(N_TAPS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic [CH_W-1:0]           in_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_data,
  output logic [CH_W-1:0]           out_ch,
  input  logic                      coef_we,
  input  logic [TAP_AW-1:0]         coef_addr,
  input  logic signed [COEFF_W-1:0] coef_wdata,
  input  logic                      coef_swap,
  output logic                      swap_pending
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int CNT_W  = $clog2(N_TAPS + 2) + 1;

  fir_state_e                state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [CNT_W-1:0]          k_q, k_d;
  logic [TAP_AW-1:0]         ptr_q [N_CH];
  logic [TAP_AW-1:0]         ptr_d [N_CH];
  logic signed [DATA_W-1:0]  dline_q [N_CH][N_TAPS];
  logic signed [DATA_W-1:0]  dline_d [N_CH][N_TAPS];
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic                      prod_vld_q, prod_vld_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]           out_ch_q, out_ch_d;

  logic [TAP_AW-1:0]         rd_idx;
  logic [TAP_AW-1:0]         rd_slot;
  logic signed [DATA_W-1:0]  x_rd;
  logic signed [COEFF_W-1:0] h_rd;

  fir_coef_bank #(
    .N_TAPS  (N_TAPS),
    .COEFF_W (COEFF_W),
    .TAP_AW  (TAP_AW),
    .COEFFS  (COEFFS)
  ) u_coef_bank (
    .clk          (clk),
    .reset_n      (reset_n),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .coef_swap    (coef_swap),
    .swap_allow   (state_q == IDLE),
    .rd_idx       (rd_idx),
    .rd_data      (h_rd),
    .swap_pending (swap_pending)
  );

  // x[n-k] lives k slots behind the channel's write pointer; k is clamped during the drain cycles.
  always_comb begin : rd_addr
    int tap;
    int slot;
    tap = int'(k_q);
    if (tap > N_TAPS - 1) tap = N_TAPS - 1;
    slot = int'(ptr_q[ch_q]) - tap;
    if (slot < 0) slot = slot + N_TAPS;
    rd_idx  = TAP_AW'(tap);
    rd_slot = TAP_AW'(slot);
    x_rd    = dline_q[ch_q][rd_slot];
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    k_d        = k_q;
    ptr_d      = ptr_q;
    dline_d    = dline_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;

    case (state_q)
      IDLE: begin
        // Samples tagged with a non-existent channel complete the handshake and are dropped.
        if (in_valid && (int'(in_ch) < N_CH)) begin
          dline_d[in_ch][ptr_q[in_ch]] = in_data;
          ch_d    = in_ch;
          k_d     = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (int'(k_q) < N_TAPS) begin
          prod_d     = PROD_W'(x_rd) * PROD_W'(h_rd);
          prod_vld_d = 1'b1;
        end
        if (prod_vld_q) acc_d = acc_q + ACC_W'(prod_q);
        // k reaches N_TAPS+1 once the last registered product has been accumulated.
        if (int'(k_q) == N_TAPS + 1) begin
          out_data_d = DATA_W'(round_sat(MAX_ACC_W'(acc_q), OUT_SHIFT, DATA_W));
          out_ch_d   = ch_q;
          state_d    = OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          ptr_d[ch_q] = (int'(ptr_q[ch_q]) == N_TAPS - 1) ? '0 : ptr_q[ch_q] + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      k_q        <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        ptr_q[c] <= '0;
        for (int t = 0; t < N_TAPS; t++) dline_q[c][t] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      k_q        <= k_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ptr_q      <= ptr_d;
      dline_q    <= dline_d;
    end
  end

  assign in_ready  = reset_n && (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_fir_tdm_mc.sv
// Randomised and directed bench for fir_tdm_mc against a per-channel history/coefficient model.
module tb_fir_tdm_mc;

  localparam int N_TAPS    = 33;
  localparam int DATA_W    = 24;
  localparam int COEFF_W   = 32;
  localparam int N_CH      = 4;
  localparam int ACC_W     = 64;
  localparam int OUT_SHIFT = 30;
  localparam int CH_W      = 2;
  localparam int TAP_AW    = 6;
  localparam longint ONE_Q = longint'(1) << OUT_SHIFT;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  in_data = '0;
  logic [CH_W-1:0]           in_ch = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic signed [DATA_W-1:0]  out_data;
  logic [CH_W-1:0]           out_ch;
  logic                      coef_we = 1'b0;
  logic [TAP_AW-1:0]         coef_addr = '0;
  logic signed [COEFF_W-1:0] coef_wdata = '0;
  logic                      coef_swap = 1'b0;
  logic                      swap_pending;

  fir_tdm_mc #(
    .N_TAPS    (N_TAPS),
    .DATA_W    (DATA_W),
    .COEFF_W   (COEFF_W),
    .N_CH      (N_CH),
    .ACC_W     (ACC_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_ch        (in_ch),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .coef_swap    (coef_swap),
    .swap_pending (swap_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: newest-first sample history per channel, plus the two coefficient banks.
  int     hist [N_CH][N_TAPS];
  longint act  [N_TAPS];
  longint shd  [N_TAPS];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < N_TAPS; k++) hist[c][k] = 0;
    for (int k = 0; k < N_TAPS; k++) begin
      act[k] = (k == 0) ? ONE_Q : 0;
      shd[k] = act[k];
    end
  endtask

  function automatic longint model_out(input int ch);
    longint acc;
    longint r;
    longint hi;
    longint lo;
    acc = 0;
    for (int k = 0; k < N_TAPS; k++) acc += longint'(hist[ch][k]) * act[k];
    r  = (acc + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    hi = (longint'(1) << (DATA_W - 1)) - 1;
    lo = -(longint'(1) << (DATA_W - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  // All tasks enter and leave on a falling edge.
  task automatic coef_write(input int addr, input longint val);
    logic [63:0] v;
    v          = 64'(val);
    coef_we    = 1'b1;
    coef_addr  = TAP_AW'(addr);
    coef_wdata = v[COEFF_W-1:0];
    @(negedge clk);
    coef_we = 1'b0;
    if (addr < N_TAPS) shd[addr] = longint'($signed(v[COEFF_W-1:0]));
  endtask

  task automatic swap_idle();
    int n;
    coef_swap = 1'b1;
    @(negedge clk);
    coef_swap = 1'b0;
    check("pending_set", longint'(swap_pending), 1);
    n = 0;
    while (swap_pending && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pending_clear", longint'(swap_pending), 0);
    for (int k = 0; k < N_TAPS; k++) act[k] = shd[k];
  endtask

  // One sample through the filter. swap_at>0 pulses coef_swap that many cycles into MAC;
  // hold>0 stalls the output for that many cycles.
  task automatic run_sample(input int ch, input int data, input int swap_at, input int hold,
                            input bit use_exp, input longint exp);
    int     n;
    bit     busy_ok;
    longint e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_data  = DATA_W'(data);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = N_TAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = data;
    e = model_out(ch);

    n       = 0;
    busy_ok = 1'b1;
    while (!out_valid && n < 200) begin
      if (in_ready) busy_ok = 1'b0;
      if (swap_at > 0 && n == swap_at) coef_swap = 1'b1;
      @(negedge clk);
      coef_swap = 1'b0;
      n++;
    end
    check("latency", n, N_TAPS + 2);
    check("in_ready_busy", longint'(busy_ok), 1);
    if (!out_valid) return;
    check("in_ready_out", longint'(in_ready), 0);
    check("out_data", longint'($signed(out_data)), e);
    check("out_ch", longint'(out_ch), ch);
    if (use_exp) check("out_data_dir", longint'($signed(out_data)), exp);
    if (swap_at > 0) check("pending_in_out", longint'(swap_pending), 1);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("bp_valid", longint'(out_valid), 1);
        check("bp_data", longint'($signed(out_data)), e);
        check("bp_ch", longint'(out_ch), ch);
        check("bp_in_ready", longint'(in_ready), 0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("out_valid_drop", longint'(out_valid), 0);
    // A swap requested mid-sample is applied on the edge after this idle cycle.
    if (swap_at > 0) begin
      check("pending_till_idle", longint'(swap_pending), 1);
      for (int k = 0; k < N_TAPS; k++) act[k] = shd[k];
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int     r;
    int     d;
    int     bad;
    int     mode;
    longint v;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'($signed(out_data)), 0);
    check("rst_out_ch", longint'(out_ch), 0);
    check("rst_pending", longint'(swap_pending), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Identity filter out of reset.
    run_sample(0, 100, 0, 0, 1, 100);
    run_sample(0, -5, 0, 0, 1, -5);

    // Interleaved channels under identity.
    for (int i = 0; i < 4; i++) begin
      run_sample(0, (i == 0) ? 500 : 0, 0, 0, 1, (i == 0) ? 500 : 0);
      run_sample(2, 7, 0, 0, 1, 7);
    end

    // Ramp impulse response on ch1; (k+1)*2^30 does not fit COEFF_W, so taps are
    // scaled by 2^-6 and the impulse by 2^6 to keep outputs 1000*(k+1).
    for (int k = 0; k < N_TAPS; k++) coef_write(k, longint'(k + 1) << 24);
    swap_idle();
    for (int i = 0; i <= N_TAPS; i++)
      run_sample(1, (i == 0) ? 64000 : 0, 0, 0, 1, (i < N_TAPS) ? 1000 * (i + 1) : 0);

    // Rounding at gain 0.5, then saturation at gain just under 2.
    for (int k = 0; k < N_TAPS; k++) coef_write(k, (k == 0) ? (longint'(1) << 29) : 0);
    swap_idle();
    run_sample(3, 3, 0, 0, 1, 2);
    run_sample(3, -3, 0, 0, 1, -1);
    coef_write(0, (longint'(1) << 31) - 1);
    swap_idle();
    run_sample(3, 8388607, 0, 0, 1, 8388607);
    run_sample(3, -8388608, 0, 0, 1, -8388608);

    // Swap requested mid-MAC: A keeps the old bank, B sees the new one.
    coef_write(0, ONE_Q);
    coef_write(1, ONE_Q);
    run_sample(2, 1000, 5, 0, 1, 2000);
    run_sample(2, 10, 0, 0, 1, 1010);

    // Shadow write on the very edge of the copy: copy sees the old shadow.
    coef_write(1, 0);
    run_sample(0, 40, 7, 0, 1, 40);
    coef_write(0, longint'(1) << 29);
    check("collide_pending", longint'(swap_pending), 0);
    run_sample(0, 600, 0, 0, 1, 600);
    swap_idle();
    run_sample(0, 600, 0, 0, 1, 300);

    // Output backpressure.
    run_sample(3, 1234, 0, 10, 1, 617);

    // Random coefficient sets, channels, data and stalls.
    for (int round = 0; round < 4; round++) begin
      for (int w = 0; w < 1 + int'($urandom_range(0, 7)); w++) begin
        r = $urandom;
        v = ($urandom_range(0, 3) == 0) ? longint'(r) : longint'(r >>> 3);
        coef_write(int'($urandom_range(0, 63)), v);
      end
      mode = int'($urandom_range(0, 1));
      if (mode == 0) swap_idle();
      for (int s = 0; s < 10; s++) begin
        d = int'($urandom_range(0, 32'h00FF_FFFF)) - 8388608;
        run_sample(int'($urandom_range(0, N_CH - 1)), d,
                   (mode == 1 && s == 0) ? int'($urandom_range(1, N_TAPS + 1)) : 0,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0, 0);
      end
    end

    // Reset in the middle of MAC abandons the sample and restores identity and zero history.
    in_valid = 1'b1;
    in_ch    = 2'd1;
    in_data  = DATA_W'(4321);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_valid", longint'(out_valid), 0);
      check("mid_rst_in_ready", longint'(in_ready), 0);
    end
    reset_n = 1'b1;
    model_reset();
    bad = 0;
    repeat (N_TAPS + 8) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("no_stale_out", bad, 0);
    check("post_rst_pending", longint'(swap_pending), 0);
    check("post_rst_out_data", longint'($signed(out_data)), 0);
    run_sample(0, 12345, 0, 0, 1, 12345);
    for (int k = 0; k < N_TAPS; k++) coef_write(k, ONE_Q);
    swap_idle();
    run_sample(1, 77, 0, 0, 1, 77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
